// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI frame receiver.
package spi_rx_pkg;
  localparam int FRAME_BITS_DEFAULT = 48;
  localparam int SD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rxstate_t;
endpackage

// File: rtl/spi_frame_rx_sync.sv
// N-flop synchronizer with asynchronous active-low reset and a selectable reset value.
module sync_bit #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [N-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= {N{RST_VAL}};
    end else begin
      sr[0] <= d;
      for (int i = 1; i < N; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[N-1];
endmodule

// File: rtl/spi_frame_rx.sv
// Oversampling SPI mode-0 slave: assembles one MSB-first frame per chip-select window
// and validates its bit count before publishing it.
module spi_frame_rx
  import spi_rx_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  int_osc,
  input  logic                  reset_n,
  input  logic                  sck,
  input  logic                  sdi,
  input  logic                  cs_n,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_valid,
  output logic                  frame_new,
  output logic                  frame_err,
  output logic                  busy
);
  localparam int CNT_W  = $clog2(FRAME_BITS + 2);
  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME_BITS + 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

  logic sck_s, sdi_s, cs_s;
  logic sck_d, cs_d;
  logic sck_rise, cs_fall, cs_rise;
  logic [WARM_W-1:0] warm;
  logic armed;

  rxstate_t state, state_nxt;
  logic [FRAME_BITS-1:0] shreg, shreg_nxt, frame_nxt;
  logic [CNT_W-1:0] bitcnt, bitcnt_nxt;
  logic valid_nxt, new_nxt, err_nxt;

  sync_bit #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(int_osc), .rst_n(reset_n), .d(sck), .q(sck_s)
  );
  sync_bit #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(int_osc), .rst_n(reset_n), .d(sdi), .q(sdi_s)
  );
  sync_bit #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(int_osc), .rst_n(reset_n), .d(cs_n), .q(cs_s)
  );

  // A window already open when reset releases would look like a fresh cs_fall once the
  // synchronizer flushes its reset value; only arm after cs_n has been seen high for real.
  always_ff @(posedge int_osc or negedge reset_n) begin
    if (!reset_n) begin
      sck_d <= 1'b0;
      cs_d  <= 1'b1;
      warm  <= '0;
      armed <= 1'b0;
    end else begin
      sck_d <= sck_s;
      cs_d  <= cs_s;
      if (warm != WARM_DONE) warm <= warm + 1'b1;
      armed <= armed | ((warm == WARM_DONE) & cs_s & cs_d);
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  always_ff @(posedge int_osc or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bitcnt      <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      frame_new   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      bitcnt      <= bitcnt_nxt;
      frame       <= frame_nxt;
      frame_valid <= valid_nxt;
      frame_new   <= new_nxt;
      frame_err   <= err_nxt;
    end
  end

  // Shift happens before the count check so a final sck rise sharing the cs rise cycle counts.
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    frame_nxt  = frame;
    valid_nxt  = 1'b0;
    new_nxt    = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          shreg_nxt  = '0;
          bitcnt_nxt = '0;
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          shreg_nxt = {shreg[FRAME_BITS-2:0], sdi_s};
          if (bitcnt != CNT_SAT) bitcnt_nxt = bitcnt + 1'b1;
        end
        if (cs_rise) begin
          state_nxt = IDLE;
          if (bitcnt_nxt == CNT_FULL) begin
            frame_nxt = shreg_nxt;
            valid_nxt = 1'b1;
            new_nxt   = (shreg_nxt != frame);
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
endmodule

// File: tb/tb_spi_frame_rx.sv
// Randomized bench for spi_frame_rx; a window-level model predicts strobes and the held frame.
module tb_spi_frame_rx;
  localparam int FB = 48;

  logic int_osc = 1'b0;
  logic reset_n = 1'b0;
  logic sck = 1'b0, sdi = 1'b0, cs_n = 1'b1;
  logic [FB-1:0] frame;
  logic frame_valid, frame_new, frame_err, busy;

  int tests = 0, fails = 0;
  int n_valid = 0, n_new = 0, n_err = 0, n_busy = 0, n_consec = 0, n_orphan = 0;
  logic prev_strobe = 1'b0;
  logic [FB-1:0] cap_frame = '0;
  int s_valid, s_new, s_err, s_busy;
  logic [FB-1:0] m_frame = '0;

  always #5 int_osc = ~int_osc;

  spi_frame_rx #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
    .int_osc(int_osc), .reset_n(reset_n), .sck(sck), .sdi(sdi), .cs_n(cs_n),
    .frame(frame), .frame_valid(frame_valid), .frame_new(frame_new),
    .frame_err(frame_err), .busy(busy)
  );

  always @(negedge int_osc) begin
    if (frame_valid) begin n_valid++; cap_frame = frame; end
    if (frame_new) n_new++;
    if (frame_err) n_err++;
    if (busy) n_busy++;
    if (frame_new && !frame_valid) n_orphan++;
    if (frame_valid && frame_err) n_consec++;
    if ((frame_valid || frame_err) && prev_strobe) n_consec++;
    prev_strobe = frame_valid | frame_err | frame_new;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge int_osc);
  endtask

  task automatic snap();
    s_valid = n_valid; s_new = n_new; s_err = n_err; s_busy = n_busy;
  endtask

  task automatic send_bits(input logic [63:0] stream, input int first, input int count,
                           input bit coincident);
    for (int i = first; i < first + count; i++) begin
      sdi = stream[63-i];
      tick(5);
      sck = 1'b1;
      if (coincident && i == first + count - 1) cs_n = 1'b1;
      tick(5);
      sck = 1'b0;
    end
  endtask

  task automatic send_window(input logic [63:0] stream, input int nbits, input bit coincident);
    cs_n = 1'b0;
    tick(6);
    send_bits(stream, 0, nbits, coincident && nbits > 0);
    tick(5);
    cs_n = 1'b1;
    tick(12);
  endtask

  // Window model: only an exact FRAME_BITS count is accepted; the frame is the bits sent, MSB first.
  task automatic model_window(input logic [63:0] stream, input int nbits,
                              output int ev, output int en, output int ee);
    logic [FB-1:0] cand;
    cand = stream[63 -: FB];
    if (nbits == FB) begin
      ev = 1; ee = 0; en = (cand != m_frame) ? 1 : 0;
      m_frame = cand;
    end else begin
      ev = 0; en = 0; ee = 1;
    end
  endtask

  task automatic test_reset();
    tick(3);
    tests++; if (frame !== '0) begin fails++; $display("FAIL reset frame: got %h want 0", frame); end
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset valid: got %b want 0", frame_valid); end
    tests++; if (frame_new !== 1'b0) begin fails++; $display("FAIL reset new: got %b want 0", frame_new); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset err: got %b want 0", frame_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", busy); end
    reset_n = 1'b1;
    tick(10);
  endtask

  task automatic test_frame(input string nm, input logic [63:0] stream, input int nbits,
                            input bit coincident);
    int ev, en, ee;
    snap();
    send_window(stream, nbits, coincident);
    model_window(stream, nbits, ev, en, ee);
    tests++; if (n_valid - s_valid !== ev) begin fails++; $display("FAIL %s valid pulses: got %0d want %0d", nm, n_valid - s_valid, ev); end
    tests++; if (n_new - s_new !== en) begin fails++; $display("FAIL %s new pulses: got %0d want %0d", nm, n_new - s_new, en); end
    tests++; if (n_err - s_err !== ee) begin fails++; $display("FAIL %s err pulses: got %0d want %0d", nm, n_err - s_err, ee); end
    tests++; if (frame !== m_frame) begin fails++; $display("FAIL %s frame: got %h want %h", nm, frame, m_frame); end
    if (ev == 1) begin
      tests++; if (cap_frame !== m_frame) begin fails++; $display("FAIL %s frame at valid: got %h want %h", nm, cap_frame, m_frame); end
    end
  endtask

  task automatic test_zero_bits();
    snap();
    send_window(64'h0, 0, 1'b0);
    tests++; if (n_err - s_err !== 1) begin fails++; $display("FAIL zero_bits err pulses: got %0d want 1", n_err - s_err); end
    tests++; if (n_valid - s_valid !== 0) begin fails++; $display("FAIL zero_bits valid pulses: got %0d want 0", n_valid - s_valid); end
    tests++; if ((n_busy - s_busy > 0) !== 1'b1) begin fails++; $display("FAIL zero_bits busy cycles: got %0d want >0", n_busy - s_busy); end
  endtask

  task automatic test_coincident();
    logic [63:0] st;
    st = {$urandom, $urandom};
    st[16] = 1'b1;
    if (st[63 -: FB] == m_frame) st[17] = ~st[17];
    test_frame("coincident_one", st, FB, 1'b1);
    st = {$urandom, $urandom};
    st[16] = 1'b0;
    if (st[63 -: FB] == m_frame) st[17] = ~st[17];
    test_frame("coincident_zero", st, FB, 1'b1);
  endtask

  task automatic test_random();
    int counts[7] = '{46, 47, 48, 48, 48, 49, 50};
    logic [63:0] st;
    int nb;
    for (int k = 0; k < 12; k++) begin
      nb = counts[$urandom_range(0, 6)];
      if ($urandom_range(0, 3) == 0) st = {m_frame, 16'h0};
      else st = {$urandom, $urandom};
      test_frame("random", st, nb, bit'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] st;
    st = {$urandom, $urandom};
    snap();
    cs_n = 1'b0;
    tick(6);
    send_bits(st, 0, 20, 1'b0);
    reset_n = 1'b0;
    tick(2);
    m_frame = '0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_reset busy: got %b want 0", busy); end
    tests++; if (frame !== '0) begin fails++; $display("FAIL mid_reset frame during reset: got %h want 0", frame); end
    reset_n = 1'b1;
    send_bits(st, 20, 28, 1'b0);
    tick(5);
    cs_n = 1'b1;
    tick(12);
    tests++; if (n_valid - s_valid !== 0) begin fails++; $display("FAIL mid_reset valid pulses: got %0d want 0", n_valid - s_valid); end
    tests++; if (n_err - s_err !== 0) begin fails++; $display("FAIL mid_reset err pulses: got %0d want 0", n_err - s_err); end
    tests++; if (frame !== '0) begin fails++; $display("FAIL mid_reset frame: got %h want 0", frame); end
    st = {$urandom | 32'h1, $urandom};
    test_frame("after_reset", st, FB, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_frame("b2b_a", {$urandom, $urandom}, FB, 1'b0);
    test_frame("b2b_b", {$urandom, $urandom}, FB, 1'b0);
    tests++; if (n_consec !== 0) begin fails++; $display("FAIL strobe spacing: got %0d violations want 0", n_consec); end
    tests++; if (n_orphan !== 0) begin fails++; $display("FAIL new without valid: got %0d want 0", n_orphan); end
  endtask

  initial begin
    test_reset();
    test_frame("first_frame", {48'h0A6414321EC8, 16'h0}, FB, 1'b0);
    test_frame("repeat_frame", {48'h0A6414321EC8, 16'h0}, FB, 1'b0);
    test_frame("short_47", {$urandom, $urandom}, 47, 1'b0);
    test_frame("long_49", {$urandom, $urandom}, 49, 1'b0);
    test_zero_bits();
    test_coincident();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
